// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // 64-bit so the digit-capacity check cannot overflow for any sane DIGITS.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] in,
    output logic [3:0] out
);

    always_comb begin
        out = (in >= ADD3_THRESH) ? in + 4'd3 : in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_LZB_EN to blank leading zero digits (digit 0 never blanked).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CW    = $clog2(WIDTH + 1);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  bcd_q, bcd_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  bcd_fmt;
    logic              acc_unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in  (acc_q[4*g +: 4]),
            .out (acc_adj[4*g +: 4])
        );
    end

    // The accumulator MSB is shifted out; the digit-capacity check keeps it zero.
    assign acc_unused_msb = acc_adj[ACC_W-1];

    always_comb begin
        bcd_fmt = acc_q;
`ifdef BCD_LZB_EN
        begin
            logic leading;
            leading = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (acc_q[4*i +: 4] == 4'd0)) begin
                    bcd_fmt[4*i +: 4] = DIGIT_BLANK;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[ACC_W-2:0], sh_q[WIDTH-1]};
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = bcd_fmt;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
